// File: rtl/uart_pkg.sv
// Shared UART definitions: parity/data-bit encodings, FSM states and line level.
// Used by both the configurable transmitter and the future receiver.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    localparam logic LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    function automatic logic [3:0] dbits_num(input logic [1:0] code);
        return 4'd5 + {2'b00, code};
    endfunction

    // Keeps only the low dbits_num(code) bits of a byte.
    function automatic logic [7:0] dbits_mask(input logic [1:0] code);
        return 8'hFF >> (2'd3 - code);
    endfunction

    function automatic logic par_enabled(input logic [1:0] par);
        return (par == PAR_EVEN) || (par == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Byte source handshake plus per-frame configuration for the UART transmitter.
interface uart_tx_cfg_if #(
    parameter int DIV_W = 16
);
    logic [DIV_W-1:0] cfg_div;
    logic [1:0]       cfg_dbits;
    logic [1:0]       cfg_par;
    logic             cfg_stop2;
    logic [7:0]       din;
    logic             din_vld;
    logic             din_rdy;

    modport master (
        output cfg_div, cfg_dbits, cfg_par, cfg_stop2, din, din_vld,
        input  din_rdy
    );

    modport slave (
        input  cfg_div, cfg_dbits, cfg_par, cfg_stop2, din, din_vld,
        output din_rdy
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Loadable bit-period counter: bit_tick marks the last clock of each bit,
// half_tick marks mid-bit for receivers that sample at the centre.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             bit_tick,
    output logic             half_tick
);
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;

    assign bit_tick  = en && (cnt_q == div_q - 1'b1);
    assign half_tick = en && (cnt_q == (div_q >> 1));

    always_comb begin
        div_d = div_q;
        cnt_d = cnt_q + 1'b1;
        if (load) div_d = div;
        if (load || !en || bit_tick) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            div_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end
endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (5-8 data bits, N/E/O parity, 1/2 stop).
// Data and configuration are captured on accept so each frame is self-consistent.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DIV_W   = 16,
    parameter int DIV_MIN = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_cfg_if.slave   bus,
    output logic           uart_tx,
    output logic           busy,
    output logic           tx_done
);
    uart_state_e state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic [2:0]  last_q, last_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        par_en_q, par_en_d;
    logic        par_bit_q, par_bit_d;
    logic        stop2_q, stop2_d;
    logic        tx_q, tx_d;

    logic             accept;
    logic             bit_tick;
    logic [DIV_W-1:0] div_eff;
    logic [7:0]       din_masked;

    assign accept     = (state_q == IDLE) && bus.din_vld;
    assign div_eff    = (bus.cfg_div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : bus.cfg_div;
    assign din_masked = bus.din & dbits_mask(bus.cfg_dbits);

    assign bus.din_rdy = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign uart_tx     = tx_q;

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .en        (busy),
        .div       (div_eff),
        .bit_tick  (bit_tick),
        .half_tick ()
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        last_d    = last_q;
        bit_cnt_d = bit_cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        tx_done   = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                data_d    = din_masked;
                // 5..8 data bits map to last bit index 4..7
                last_d    = {1'b1, bus.cfg_dbits};
                par_en_d  = par_enabled(bus.cfg_par);
                par_bit_d = (^din_masked) ^ (bus.cfg_par == PAR_ODD);
                stop2_d   = bus.cfg_stop2;
                state_d   = START;
            end
            START: if (bit_tick) state_d = DATA;
            DATA: if (bit_tick) begin
                data_d = data_q >> 1;
                if (bit_cnt_q == last_q) begin
                    bit_cnt_d = '0;
                    state_d   = par_en_q ? PARITY : STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            PARITY: if (bit_tick) state_d = STOP;
            // bit_cnt is reused to count stop bits
            STOP: if (bit_tick) begin
                if (bit_cnt_q == {2'b00, stop2_q}) begin
                    bit_cnt_d = '0;
                    tx_done   = 1'b1;
                    state_d   = IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line is registered from the next state so it is glitch-free.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[0];
            PARITY:  tx_d = par_bit_d;
            default: tx_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            data_q    <= '0;
            last_q    <= '0;
            bit_cnt_q <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= LINE_IDLE;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            last_q    <= last_d;
            bit_cnt_q <= bit_cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: directed frames plus randomized frames
// compared cycle by cycle against a bit-list model of the serial frame.
module tb_uart_tx_cfg;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic uart_tx, busy, tx_done;

    always #5 clk = ~clk;

    uart_tx_cfg_if #(.DIV_W(16)) bus ();

    uart_tx_cfg #(.DIV_W(16), .DIV_MIN(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .uart_tx (uart_tx),
        .busy    (busy),
        .tx_done (tx_done)
    );

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level for every clock of the frame, built from the frame format.
    function automatic void build_frame(input logic [7:0] d, input int div, input int db,
                                        input int par, input bit st2);
        bit bits[$];
        bit p = 1'b0;
        int n = (div < 2) ? 2 : div;
        int nbits = 5 + db;
        exp_q.delete();
        bits.push_back(1'b0);
        for (int i = 0; i < nbits; i++) begin
            bits.push_back(d[i]);
            p ^= d[i];
        end
        if (par == 1) bits.push_back(p);
        if (par == 2) bits.push_back(~p);
        bits.push_back(1'b1);
        if (st2) bits.push_back(1'b1);
        foreach (bits[b])
            for (int c = 0; c < n; c++) exp_q.push_back(bits[b]);
    endfunction

    // Called at a negedge with the DUT idle; accept happens on the next posedge.
    task automatic run_frame(input string tag, input logic [7:0] d, input int div,
                             input int db, input int par, input bit st2,
                             input bit keep_vld, input int abort_at);
        int len;
        check({tag, "_rdy_before"}, 32'(bus.din_rdy), 32'd1);
        bus.din       = d;
        bus.cfg_div   = 16'(div);
        bus.cfg_dbits = 2'(db);
        bus.cfg_par   = 2'(par);
        bus.cfg_stop2 = st2;
        bus.din_vld   = 1'b1;
        build_frame(d, div, db, par, st2);
        len = exp_q.size();
        @(posedge clk);
        @(negedge clk);
        if (!keep_vld) bus.din_vld = 1'b0;
        // Garbage on the inputs mid-frame must not disturb the latched frame.
        bus.din       = 8'($urandom);
        bus.cfg_div   = 16'($urandom_range(0, 15));
        bus.cfg_dbits = 2'($urandom);
        bus.cfg_par   = 2'($urandom);
        bus.cfg_stop2 = 1'($urandom);
        for (int k = 0; k < len; k++) begin
            if (k == abort_at) begin
                check({tag, "_busy_pre_rst"}, 32'(busy), 32'd1);
                bus.din_vld = 1'b0;
                rst_n = 1'b0;
                #1;
                check({tag, "_rst_line"}, 32'(uart_tx), 32'd1);
                check({tag, "_rst_busy"}, 32'(busy), 32'd0);
                check({tag, "_rst_rdy"}, 32'(bus.din_rdy), 32'd1);
                check({tag, "_rst_done"}, 32'(tx_done), 32'd0);
                @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            check({tag, "_line"}, 32'(uart_tx), 32'(exp_q[k]));
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_rdy"}, 32'(bus.din_rdy), 32'd0);
            check({tag, "_done"}, 32'(tx_done), 32'(k == len - 1));
            if (k < len - 1) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check({tag, "_idle_line"}, 32'(uart_tx), 32'd1);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_rdy"}, 32'(bus.din_rdy), 32'd1);
        check({tag, "_idle_done"}, 32'(tx_done), 32'd0);
    endtask

    initial begin
        bus.din       = 8'h00;
        bus.din_vld   = 1'b0;
        bus.cfg_div   = 16'd4;
        bus.cfg_dbits = 2'b11;
        bus.cfg_par   = 2'b00;
        bus.cfg_stop2 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_line", 32'(uart_tx), 32'd1);
        check("reset_rdy", 32'(bus.din_rdy), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(tx_done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame("8N1",      8'h55, 4, 3, 0, 1'b0, 1'b0, -1);
        run_frame("7E1",      8'hC1, 3, 2, 1, 1'b0, 1'b0, -1);
        run_frame("8O2",      8'hFF, 3, 3, 2, 1'b1, 1'b0, -1);
        run_frame("5N1clamp", 8'h3A, 0, 0, 0, 1'b0, 1'b0, -1);
        run_frame("b2b_a",    8'h12, 5, 3, 0, 1'b0, 1'b1, -1);
        run_frame("b2b_b",    8'h34, 3, 1, 2, 1'b1, 1'b0, -1);
        run_frame("midrst",   8'hA5, 4, 3, 1, 1'b0, 1'b0, 16);
        run_frame("post_rst", 8'hA5, 4, 3, 1, 1'b0, 1'b0, -1);

        for (int i = 0; i < 40; i++) begin
            run_frame("rand", 8'($urandom), int'($urandom_range(0, 9)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom), (i < 39) ? 1'($urandom) : 1'b0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
